// File: rtl/int_input_ctrl.sv
// int_input_ctrl: synchronise, debounce and latch N button/interrupt lines
// into masked, priority-encoded CPU interrupt requests.
module int_input_ctrl #(
  parameter int N_CH            = 7,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2,
  parameter int ID_W            = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            CLK100MHZ,
  input  logic            CPU_RESET,
  input  logic [N_CH-1:0] btn_in,
  input  logic [N_CH-1:0] mode,
  input  logic [N_CH-1:0] mask,
  input  logic [N_CH-1:0] int_clr,
  output logic [N_CH-1:0] btn_state,
  output logic [N_CH-1:0] pending,
  output logic [N_CH-1:0] int_out,
  output logic            irq_any,
  output logic [ID_W-1:0] irq_id
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_CH-1:0] sync_q [SYNC_STAGES];
  logic [N_CH-1:0] sync;
  logic [CW-1:0]   cnt [N_CH];
  logic [N_CH-1:0] btn_state_d;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] masked;
  logic [ID_W-1:0] id_nxt;

  assign sync   = sync_q[SYNC_STAGES-1];
  assign rise   = btn_state & ~btn_state_d;
  assign masked = pending & ~mask;

  // Metastability synchroniser chain for the raw pins
  always_ff @(posedge CLK100MHZ or posedge CPU_RESET) begin
    if (CPU_RESET) begin
      for (int s = 0; s < SYNC_STAGES; s++)
        sync_q[s] <= '0;
    end else begin
      sync_q[0] <= btn_in;
      for (int s = 1; s < SYNC_STAGES; s++)
        sync_q[s] <= sync_q[s-1];
    end
  end

  // Accept a new level only after it has been stable for the full period
  always_ff @(posedge CLK100MHZ or posedge CPU_RESET) begin
    if (CPU_RESET) begin
      btn_state <= '0;
      for (int i = 0; i < N_CH; i++)
        cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (sync[i] == btn_state[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          btn_state[i] <= sync[i];
          cnt[i]       <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Edge-mode channels latch rises (set beats clear); level-mode follow state
  always_ff @(posedge CLK100MHZ or posedge CPU_RESET) begin
    if (CPU_RESET) begin
      btn_state_d <= '0;
      pending     <= '0;
    end else begin
      btn_state_d <= btn_state;
      pending     <= (mode & (rise | (pending & ~int_clr)))
                   | (~mode & btn_state);
    end
  end

  // Lowest-index unmasked pending channel wins
  always_comb begin
    id_nxt = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (masked[i])
        id_nxt = ID_W'(i);
  end

  // Register the CPU-facing outputs together so they stay coherent
  always_ff @(posedge CLK100MHZ or posedge CPU_RESET) begin
    if (CPU_RESET) begin
      int_out <= '0;
      irq_any <= 1'b0;
      irq_id  <= '0;
    end else begin
      int_out <= masked;
      irq_any <= |masked;
      irq_id  <= id_nxt;
    end
  end

endmodule

// File: tb/tb_int_input_ctrl.sv
// tb_int_input_ctrl: directed scenarios for int_input_ctrl with
// N_CH=4, DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
module tb_int_input_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_in, mode, mask, int_clr;
  logic [3:0] btn_state, pending, int_out;
  logic       irq_any;
  logic [1:0] irq_id;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  int_input_ctrl #(
    .N_CH(4),
    .DEBOUNCE_CYCLES(4),
    .SYNC_STAGES(2)
  ) dut (
    .CLK100MHZ(clk),
    .CPU_RESET(rst),
    .btn_in(btn_in),
    .mode(mode),
    .mask(mask),
    .int_clr(int_clr),
    .btn_state(btn_state),
    .pending(pending),
    .int_out(int_out),
    .irq_any(irq_any),
    .irq_id(irq_id)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; btn_in = '0; mode = '0; mask = '0; int_clr = '0;
    step(3);
    checks++;
    if ({btn_state, pending, int_out, irq_any, irq_id} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=0",
               {btn_state, pending, int_out, irq_any, irq_id});
    end
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_clean_press();
    mode = 4'b0100; mask = '0;
    btn_in = 4'b0100;
    step(5);
    checks++;
    if (btn_state !== 4'b0000) begin
      errors++; $display("FAIL press_early_state got=%b want=0000", btn_state);
    end
    step(1);
    checks++;
    if (btn_state !== 4'b0100 || pending !== 4'b0000) begin
      errors++;
      $display("FAIL press_state6 got=%b/%b want=0100/0000", btn_state, pending);
    end
    step(1);
    checks++;
    if (pending !== 4'b0100 || int_out !== 4'b0000) begin
      errors++;
      $display("FAIL press_pend7 got=%b/%b want=0100/0000", pending, int_out);
    end
    step(1);
    checks++;
    if (int_out !== 4'b0100 || irq_any !== 1'b1 || irq_id !== 2'd2) begin
      errors++;
      $display("FAIL press_int8 got=%b/%b/%0d want=0100/1/2",
               int_out, irq_any, irq_id);
    end
    btn_in = '0;
    step(10);
    checks++;
    if (btn_state !== 4'b0000 || pending !== 4'b0100) begin
      errors++;
      $display("FAIL release_sticky got=%b/%b want=0000/0100", btn_state, pending);
    end
    int_clr = 4'b0100;
    step(1);
    int_clr = '0;
    step(2);
    checks++;
    if (pending !== 4'b0000 || int_out !== 4'b0000) begin
      errors++;
      $display("FAIL press_cleanup got=%b/%b want=0/0", pending, int_out);
    end
  endtask

  task automatic test_bounce();
    logic [3:0] seen;
    seen = '0;
    mode = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      btn_in[1] = ~k[0];
      for (int c = 0; c < 2; c++) begin
        step(1);
        seen |= btn_state | pending | int_out;
      end
    end
    btn_in[1] = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step(1);
      seen |= btn_state | pending | int_out;
    end
    checks++;
    if (seen !== 4'b0000) begin
      errors++; $display("FAIL bounce_reject got=%b want=0000", seen);
    end
  endtask

  task automatic test_w1c();
    mode = 4'b0001;
    btn_in[0] = 1'b1;
    step(8);
    checks++;
    if (pending !== 4'b0001 || int_out !== 4'b0001) begin
      errors++;
      $display("FAIL w1c_setup got=%b/%b want=0001/0001", pending, int_out);
    end
    int_clr = 4'b0001;
    step(1);
    int_clr = '0;
    checks++;
    if (pending !== 4'b0000 || int_out !== 4'b0001) begin
      errors++;
      $display("FAIL w1c_clear got=%b/%b want=0000/0001", pending, int_out);
    end
    step(1);
    checks++;
    if (int_out !== 4'b0000) begin
      errors++; $display("FAIL w1c_intout got=%b want=0000", int_out);
    end
    btn_in[0] = 1'b0;
    step(8);
    btn_in[0] = 1'b1;
    step(6);
    int_clr = 4'b0001;
    step(1);
    int_clr = '0;
    checks++;
    if (pending !== 4'b0001) begin
      errors++; $display("FAIL w1c_set_wins got=%b want=0001", pending);
    end
    btn_in[0] = 1'b0;
    step(8);
    int_clr = 4'b0001;
    step(1);
    int_clr = '0;
    step(2);
  endtask

  task automatic test_level_mask();
    mode = 4'b0001; mask = '0;
    btn_in[3] = 1'b1;
    step(6);
    checks++;
    if (btn_state !== 4'b1000 || pending !== 4'b0000) begin
      errors++;
      $display("FAIL level_state got=%b/%b want=1000/0000", btn_state, pending);
    end
    step(1);
    checks++;
    if (pending !== 4'b1000) begin
      errors++; $display("FAIL level_pend got=%b want=1000", pending);
    end
    step(1);
    checks++;
    if (int_out !== 4'b1000 || irq_any !== 1'b1 || irq_id !== 2'd3) begin
      errors++;
      $display("FAIL level_int got=%b/%b/%0d want=1000/1/3",
               int_out, irq_any, irq_id);
    end
    int_clr = 4'b1000;
    step(2);
    int_clr = '0;
    checks++;
    if (pending !== 4'b1000 || int_out !== 4'b1000) begin
      errors++;
      $display("FAIL level_clr_ignored got=%b/%b want=1000/1000", pending, int_out);
    end
    mask = 4'b1000;
    step(1);
    checks++;
    if (int_out !== 4'b0000 || irq_any !== 1'b0 || pending !== 4'b1000) begin
      errors++;
      $display("FAIL level_mask got=%b/%b/%b want=0000/0/1000",
               int_out, irq_any, pending);
    end
    btn_in[3] = 1'b0;
    step(7);
    checks++;
    if (pending !== 4'b0000 || btn_state !== 4'b0000) begin
      errors++;
      $display("FAIL level_release got=%b/%b want=0000/0000", pending, btn_state);
    end
    mask = '0;
    step(2);
  endtask

  task automatic test_priority();
    mode = 4'b0000; mask = '0;
    btn_in = 4'b1010;
    step(8);
    checks++;
    if (pending !== 4'b1010 || int_out !== 4'b1010 || irq_id !== 2'd1) begin
      errors++;
      $display("FAIL prio_lowest got=%b/%b/%0d want=1010/1010/1",
               pending, int_out, irq_id);
    end
    mask = 4'b0010;
    step(1);
    checks++;
    if (irq_id !== 2'd3 || irq_any !== 1'b1) begin
      errors++;
      $display("FAIL prio_masked1 got=%0d/%b want=3/1", irq_id, irq_any);
    end
    mask = 4'b1010;
    step(1);
    checks++;
    if (irq_id !== 2'd0 || irq_any !== 1'b0 || int_out !== 4'b0000) begin
      errors++;
      $display("FAIL prio_none got=%0d/%b/%b want=0/0/0000",
               irq_id, irq_any, int_out);
    end
    btn_in = '0; mask = '0;
    step(8);
  endtask

  task automatic test_reset_mid();
    mode = 4'b0001;
    btn_in = 4'b0001;
    step(8);
    btn_in = 4'b0011;
    step(4);
    checks++;
    if (pending !== 4'b0001 || btn_state !== 4'b0001) begin
      errors++;
      $display("FAIL rst_mid_setup got=%b/%b want=0001/0001", pending, btn_state);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({btn_state, pending, int_out, irq_any, irq_id} !== 15'd0) begin
      errors++;
      $display("FAIL rst_async got=%h want=0",
               {btn_state, pending, int_out, irq_any, irq_id});
    end
    btn_in = 4'b0001;
    step(2);
    rst = 1'b0;
    step(6);
    checks++;
    if (pending !== 4'b0000 || btn_state !== 4'b0001) begin
      errors++;
      $display("FAIL rst_requal6 got=%b/%b want=0000/0001", pending, btn_state);
    end
    step(1);
    checks++;
    if (pending !== 4'b0001) begin
      errors++; $display("FAIL rst_requal7 got=%b want=0001", pending);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_w1c();
    test_level_mask();
    test_priority();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
